// File: rtl/fir_avg_sched_if.sv
// rtl/fir_avg_sched_if.sv - channel-input and result-output bundle for fir_avg_sched
interface fir_avg_sched_if #(
    parameter int W   = 16,
    parameter int NCH = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [NCH-1:0]   hist_clr;
    logic [W+1:0]     out_data;
    logic [CW-1:0]    out_ch;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, hist_clr, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, hist_clr, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/fir_avg_sched.sv
// rtl/fir_avg_sched.sv - round-robin scheduler sharing one 4-tap sum datapath among NCH channels
// Define FIR_SCHED_AVG_EN to emit the truncating 4-tap average instead of the full sum.
module fir_avg_sched #(
    parameter int W   = 16,
    parameter int NCH = 4
) (
    input logic            clk,
    input logic            rst,
    fir_avg_sched_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = W + 2;

    logic [W-1:0]  h_q [NCH][3];
    logic [W-1:0]  h_d [NCH][3];
    logic [CW-1:0] p_q, p_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q, out_ch_d;

    logic [W-1:0]  in_word [NCH];
    logic          hi_found, lo_found, gnt_found;
    logic [CW-1:0] hi_idx, lo_idx, gnt_idx;
    logic          stall, accept, clr_g;
    logic [W-1:0]  x;
    logic [SW-1:0] sum, out_word;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            in_word[i] = bus.in_data[i*W +: W];
        end
    end

    // Two priority searches: channels at/after the pointer win over the wrapped-around ones.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = CW'(i);
                if (CW'(i) >= p_q) begin
                    hi_found = 1'b1;
                    hi_idx   = CW'(i);
                end
            end
        end
        gnt_found = hi_found | lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign stall  = out_valid_q & ~bus.out_ready;
    assign accept = gnt_found & ~stall & ~rst;
    assign x      = in_word[gnt_idx];
    assign clr_g  = bus.hist_clr[gnt_idx];
    assign sum    = SW'(x) + (clr_g ? SW'(0)
                    : (SW'(h_q[gnt_idx][0]) + SW'(h_q[gnt_idx][1]) + SW'(h_q[gnt_idx][2])));

`ifdef FIR_SCHED_AVG_EN
    assign out_word = {2'b00, sum[SW-1:2]};
`else
    assign out_word = sum;
`endif

    always_comb begin
        bus.in_ready = '0;
        if (accept) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            for (int t = 0; t < 3; t++) begin
                h_d[i][t] = bus.hist_clr[i] ? '0 : h_q[i][t];
            end
            if (accept && (gnt_idx == CW'(i))) begin
                h_d[i][0] = x;
                h_d[i][1] = bus.hist_clr[i] ? '0 : h_q[i][0];
                h_d[i][2] = bus.hist_clr[i] ? '0 : h_q[i][1];
            end
        end
    end

    always_comb begin
        p_d         = p_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            p_d         = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
            out_valid_d = 1'b1;
            out_data_d  = out_word;
            out_ch_d    = gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                for (int t = 0; t < 3; t++) begin
                    h_q[i][t] <= '0;
                end
            end
            p_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                for (int t = 0; t < 3; t++) begin
                    h_q[i][t] <= h_d[i][t];
                end
            end
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_fir_avg_sched.sv
// tb/tb_fir_avg_sched.sv - vector table, corner sequences and random model check of fir_avg_sched
module tb_fir_avg_sched;
    localparam int W   = 16;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fir_avg_sched_if #(.W(W), .NCH(NCH)) bus ();
    fir_avg_sched #(.W(W), .NCH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [3:0]  clr;
        logic        ordy;
        logic [15:0] x;
        logic [3:0]  er;
        logic        eov;
        logic [17:0] eod;
        logic [1:0]  ech;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] exp_out(input logic [31:0] s);
`ifdef FIR_SCHED_AVG_EN
        return s / 4;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input string name, input logic r, input logic [3:0] v, input logic [3:0] clr,
                       input logic ordy, input logic [15:0] x, input logic [3:0] er,
                       input logic eov, input logic [17:0] eod, input logic [1:0] ech);
        @(negedge clk);
        rst           = r;
        bus.in_valid  = v;
        bus.hist_clr  = clr;
        bus.out_ready = ordy;
        bus.in_data   = {NCH{x}};
        #1;
        chk({name, " in_ready"}, 32'(bus.in_ready), 32'(er));
        @(posedge clk);
        #1;
        chk({name, " out_valid"}, 32'(bus.out_valid), 32'(eov));
        if (eov) begin
            chk({name, " out_data"}, 32'(bus.out_data), exp_out(32'(eod)));
            chk({name, " out_ch"}, 32'(bus.out_ch), 32'(ech));
        end
    endtask

    int          mh [NCH][3];
    int          mp, md, mc, g, s;
    bit          mv, stall, r_b, o_b;
    logic [3:0]  v_r, clr_r, er_r;
    logic [15:0] xs [NCH];

    initial begin
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.hist_clr  = '0;
        bus.out_ready = 1'b1;
        bus.in_data   = '0;

        // ch0 alone: 1..5 -> running 4-tap sums
        tbl.push_back(vec_t'{1, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0});
        for (int k = 1; k <= 5; k++)
            tbl.push_back(vec_t'{0, 4'b0001, 4'b0000, 1, 16'(k), 4'b0001, 1,
                                 18'((k == 5) ? 14 : k * (k + 1) / 2), 2'd0});
        tbl.push_back(vec_t'{0, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0});
        // all channels valid: strict rotation 0,1,2,3,0,1,2,3
        tbl.push_back(vec_t'{1, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0});
        for (int k = 0; k < 8; k++)
            tbl.push_back(vec_t'{0, 4'b1111, 4'b0000, 1, 16'd1, 4'(1 << (k % 4)), 1,
                                 18'(k / 4 + 1), 2'(k % 4)});
        // ch2 full-scale: no overflow at 4*(2^W-1)
        tbl.push_back(vec_t'{1, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0});
        for (int k = 1; k <= 4; k++)
            tbl.push_back(vec_t'{0, 4'b0100, 4'b0000, 1, 16'hFFFF, 4'b0100, 1,
                                 18'(k * 65535), 2'd2});
        // ch1 history {3,2,1}, clear with sample 7, then 1
        tbl.push_back(vec_t'{1, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0});
        tbl.push_back(vec_t'{0, 4'b0010, 4'b0000, 1, 16'd1, 4'b0010, 1, 18'd1, 2'd1});
        tbl.push_back(vec_t'{0, 4'b0010, 4'b0000, 1, 16'd2, 4'b0010, 1, 18'd3, 2'd1});
        tbl.push_back(vec_t'{0, 4'b0010, 4'b0000, 1, 16'd3, 4'b0010, 1, 18'd6, 2'd1});
        tbl.push_back(vec_t'{0, 4'b0010, 4'b0010, 1, 16'd7, 4'b0010, 1, 18'd7, 2'd1});
        tbl.push_back(vec_t'{0, 4'b0010, 4'b0000, 1, 16'd1, 4'b0010, 1, 18'd8, 2'd1});
        tbl.push_back(vec_t'{0, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0});

        foreach (tbl[i])
            cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].v, tbl[i].clr, tbl[i].ordy, tbl[i].x,
                tbl[i].er, tbl[i].eov, tbl[i].eod, tbl[i].ech);

        // stall: out_ready low three cycles, ch1 waits and is taken on release
        cyc("stall_rst", 1, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0);
        cyc("stall_pre", 0, 4'b0010, 4'b0000, 1, 16'd10, 4'b0010, 1, 18'd10, 2'd1);
        for (int k = 0; k < 3; k++)
            cyc($sformatf("stall%0d", k), 0, 4'b0010, 4'b0000, 0, 16'd20, 4'b0000, 1, 18'd10, 2'd1);
        cyc("stall_rel", 0, 4'b0010, 4'b0000, 1, 16'd20, 4'b0010, 1, 18'd30, 2'd1);
        cyc("stall_idle", 0, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0);

        // reset mid-stream drops the pending output and all history
        cyc("mrst_pre", 0, 4'b0001, 4'b0000, 1, 16'd3, 4'b0001, 1, 18'd3, 2'd0);
        cyc("mrst", 1, 4'b0001, 4'b0000, 1, 16'd3, 4'b0000, 0, 18'd0, 2'd0);
        chk("mrst out_data", 32'(bus.out_data), 32'd0);
        chk("mrst out_ch", 32'(bus.out_ch), 32'd0);
        cyc("mrst_post", 0, 4'b0001, 4'b0000, 1, 16'd5, 4'b0001, 1, 18'd5, 2'd0);

        // random traffic against a plain-arithmetic model
        cyc("rnd_rst", 1, 4'b0000, 4'b0000, 1, 16'd0, 4'b0000, 0, 18'd0, 2'd0);
        foreach (mh[c, t]) mh[c][t] = 0;
        mp = 0; mv = 0; md = 0; mc = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            r_b   = ($urandom_range(0, 79) == 0);
            v_r   = 4'($urandom);
            clr_r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            o_b   = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NCH; c++) begin
                xs[c] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                bus.in_data[c*W +: W] = xs[c];
            end
            rst           = r_b;
            bus.in_valid  = v_r;
            bus.hist_clr  = clr_r;
            bus.out_ready = o_b;

            stall = mv && !o_b;
            g = -1;
            if (!r_b && !stall)
                for (int k = 0; k < NCH; k++)
                    if (g < 0 && v_r[(mp + k) % NCH]) g = (mp + k) % NCH;
            er_r = (g >= 0) ? 4'(1 << g) : 4'b0000;
            #1;
            chk($sformatf("rnd%0d in_ready", n), 32'(bus.in_ready), 32'(er_r));
            @(posedge clk);
            #1;
            if (r_b) begin
                foreach (mh[c, t]) mh[c][t] = 0;
                mp = 0; mv = 0; md = 0; mc = 0;
            end else begin
                s = 0;
                for (int c = 0; c < NCH; c++) begin
                    if (c == g) begin
                        if (clr_r[c]) begin
                            s = xs[c];
                            mh[c][2] = 0; mh[c][1] = 0;
                        end else begin
                            s = xs[c] + mh[c][0] + mh[c][1] + mh[c][2];
                            mh[c][2] = mh[c][1]; mh[c][1] = mh[c][0];
                        end
                        mh[c][0] = xs[c];
                    end else if (clr_r[c]) begin
                        mh[c][0] = 0; mh[c][1] = 0; mh[c][2] = 0;
                    end
                end
                if (g >= 0) begin
                    mv = 1; md = s; mc = g; mp = (g + 1) % NCH;
                end else if (o_b) begin
                    mv = 0;
                end
            end
            chk($sformatf("rnd%0d out_valid", n), 32'(bus.out_valid), 32'(mv));
            if (mv) begin
                chk($sformatf("rnd%0d out_data", n), 32'(bus.out_data), exp_out(32'(md)));
                chk($sformatf("rnd%0d out_ch", n), 32'(bus.out_ch), 32'(mc));
            end
            if (r_b) chk($sformatf("rnd%0d rst out_data", n), 32'(bus.out_data), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
